// File: rtl/shift_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_reg_pkg
// Brief    : Operation encodings and sizing helpers for the universal shifter.
// Revision : 1.0 - initial release
// ============================================================================
package shift_reg_pkg;

   localparam int MODE_W = 3;

   // Encodings 6 and 7 are reserved and decode as HOLD.
   typedef enum logic [MODE_W-1:0] {
      MODE_HOLD = 3'd0,
      MODE_SHL  = 3'd1,
      MODE_SHR  = 3'd2,
      MODE_ROTL = 3'd3,
      MODE_ROTR = 3'd4,
      MODE_LOAD = 3'd5
   } shift_mode_t;

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/shift_register_univ_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_register_univ_if
// Brief    : Control, data and status bundle of the universal shift register.
// Revision : 1.0 - initial release
// ============================================================================
interface shift_register_univ_if
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8
) ();

   logic                          shift_enable;
   logic [MODE_W-1:0]             mode;
   logic                          data_in;
   logic [WIDTH-1:0]              load_data;
   logic [WIDTH-1:0]              data_out;
   logic                          serial_out;
   logic                          word_valid;
   logic [cnt_width(WIDTH)-1:0]   bit_count;

   modport master (
      output shift_enable, mode, data_in, load_data,
      input  data_out, serial_out, word_valid, bit_count
   );

   modport slave (
      input  shift_enable, mode, data_in, load_data,
      output data_out, serial_out, word_valid, bit_count
   );

endinterface
`default_nettype wire

// File: rtl/shift_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : shift_bit_counter
// Brief    : Counts serial shifts and pulses word_valid when a word completes.
// Revision : 1.0 - initial release
// ============================================================================
module shift_bit_counter
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  wire logic                        clk,
   input  wire logic                        rst,
   input  wire logic                        count_en,
   input  wire logic                        clear,
   output logic [cnt_width(WIDTH)-1:0]      bit_count,
   output logic                             word_valid
);

   localparam int                CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

   logic [CW-1:0] count_d, count_q;
   logic          valid_d, valid_q;

   always_comb begin
      count_d = count_q;
      valid_d = 1'b0;
      if (clear) begin
         count_d = '0;
      end else if (count_en) begin
         // The shift that completes a word restarts the count and flags it.
         if (count_q == LAST) begin
            count_d = '0;
            valid_d = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         valid_q <= 1'b0;
      end else begin
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

   assign bit_count  = count_q;
   assign word_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/shift_register_univ.sv
`default_nettype none
// ============================================================================
// Module   : shift_register_univ
// Brief    : Universal shift register: shift, rotate, parallel load and hold.
// Revision : 1.0 - initial release
// ============================================================================
module shift_register_univ
   import shift_reg_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  wire logic                clk,
   input  wire logic                rst,
   shift_register_univ_if.slave     bus
);

   shift_mode_t              mode_s;
   logic [WIDTH-1:0]         data_d, data_q;
   logic                     serial_d, serial_q;
   logic                     count_en;
   logic                     count_clr;
   logic [cnt_width(WIDTH)-1:0] bit_count_s;
   logic                     word_valid_s;

   assign mode_s = shift_mode_t'(bus.mode);

   always_comb begin
      data_d   = data_q;
      serial_d = serial_q;
      if (bus.shift_enable) begin
         case (mode_s)
            MODE_SHL: begin
               data_d   = {data_q[WIDTH-2:0], bus.data_in};
               serial_d = data_q[WIDTH-1];
            end
            MODE_SHR: begin
               data_d   = {bus.data_in, data_q[WIDTH-1:1]};
               serial_d = data_q[0];
            end
            MODE_ROTL: begin
               data_d   = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
               serial_d = data_q[WIDTH-1];
            end
            MODE_ROTR: begin
               data_d   = {data_q[0], data_q[WIDTH-1:1]};
               serial_d = data_q[0];
            end
            MODE_LOAD: begin
               data_d = bus.load_data;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q   <= RESET_VAL;
         serial_q <= 1'b0;
      end else begin
         data_q   <= data_d;
         serial_q <= serial_d;
      end
   end

   // Only true serial shifts advance the word count; rotates recirculate data.
   assign count_en  = bus.shift_enable && ((mode_s == MODE_SHL) || (mode_s == MODE_SHR));
   assign count_clr = bus.shift_enable && (mode_s == MODE_LOAD);

   shift_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk        (clk),
      .rst        (rst),
      .count_en   (count_en),
      .clear      (count_clr),
      .bit_count  (bit_count_s),
      .word_valid (word_valid_s)
   );

   assign bus.data_out   = data_q;
   assign bus.serial_out = serial_q;
   assign bus.bit_count  = bit_count_s;
   assign bus.word_valid = word_valid_s;

endmodule
`default_nettype wire

// File: tb/tb_shift_register_univ.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_register_univ
// Brief    : Bench driving WIDTH=8, 16 and 2 instances in lockstep with a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_register_univ;
   import shift_reg_pkg::*;

   typedef struct packed {
      logic [63:0] d;
      logic        so;
      logic [6:0]  bc;
      logic        wv;
   } snap_t;
   typedef snap_t [2:0] snap3_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        se = 1'b0;
   logic [2:0]  mode = 3'd0;
   logic        din = 1'b0;
   logic [63:0] ld = '0;

   int errors = 0;
   int checks = 0;

   snap3_t exp_q[$];
   snap3_t obs_q[$];

   logic [63:0] m_d [3];
   logic        m_so[3];
   int          m_bc[3];
   logic        m_wv[3];
   int          w   [3] = '{8, 16, 2};
   logic [63:0] rv  [3] = '{64'h3C, 64'h0, 64'h2};

   always #5 clk = ~clk;

   shift_register_univ_if #(.WIDTH(8))  if8 ();
   shift_register_univ_if #(.WIDTH(16)) if16 ();
   shift_register_univ_if #(.WIDTH(2))  if2 ();

   assign if8.shift_enable  = se;   assign if8.mode  = mode; assign if8.data_in  = din;
   assign if16.shift_enable = se;   assign if16.mode = mode; assign if16.data_in = din;
   assign if2.shift_enable  = se;   assign if2.mode  = mode; assign if2.data_in  = din;
   assign if8.load_data  = ld[7:0];
   assign if16.load_data = ld[15:0];
   assign if2.load_data  = ld[1:0];

   shift_register_univ #(.WIDTH(8),  .RESET_VAL(8'h3C))     u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
   shift_register_univ #(.WIDTH(16), .RESET_VAL(16'h0000))  u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
   shift_register_univ #(.WIDTH(2),  .RESET_VAL(2'b10))     u_dut2  (.clk(clk), .rst(rst), .bus(if2.slave));

   task automatic model_step(input logic r, input logic s, input logic [2:0] m,
                             input logic di, input logic [63:0] l);
      for (int k = 0; k < 3; k++) begin
         logic [63:0] mask;
         logic        shifted;
         mask    = (64'd1 << w[k]) - 64'd1;
         shifted = 1'b0;
         m_wv[k] = 1'b0;
         if (r) begin
            m_d[k] = rv[k]; m_so[k] = 1'b0; m_bc[k] = 0;
         end else if (s) begin
            case (m)
               3'd1: begin m_so[k] = m_d[k][w[k]-1]; m_d[k] = ((m_d[k] << 1) | 64'(di)) & mask; shifted = 1'b1; end
               3'd2: begin m_so[k] = m_d[k][0]; m_d[k] = (m_d[k] >> 1) | (64'(di) << (w[k]-1)); shifted = 1'b1; end
               3'd3: begin m_so[k] = m_d[k][w[k]-1]; m_d[k] = ((m_d[k] << 1) | 64'(m_d[k][w[k]-1])) & mask; end
               3'd4: begin m_so[k] = m_d[k][0]; m_d[k] = (m_d[k] >> 1) | (64'(m_d[k][0]) << (w[k]-1)); end
               3'd5: begin m_d[k] = l & mask; m_bc[k] = 0; end
               default: ;
            endcase
            if (shifted) begin
               if (m_bc[k] == w[k] - 1) begin m_bc[k] = 0; m_wv[k] = 1'b1; end
               else m_bc[k] = m_bc[k] + 1;
            end
         end
      end
   endtask

   // Applies one cycle of stimulus, records the model prediction and the DUT result.
   task automatic drive(input logic r, input logic s, input logic [2:0] m,
                        input logic di, input logic [63:0] l);
      snap3_t e, o;
      @(negedge clk);
      rst = r; se = s; mode = m; din = di; ld = l;
      model_step(r, s, m, di, l);
      for (int k = 0; k < 3; k++) e[k] = {m_d[k], m_so[k], 7'(m_bc[k]), m_wv[k]};
      exp_q.push_back(e);
      @(posedge clk); #1;
      o[0] = {64'(if8.data_out),  if8.serial_out,  7'(if8.bit_count),  if8.word_valid};
      o[1] = {64'(if16.data_out), if16.serial_out, 7'(if16.bit_count), if16.word_valid};
      o[2] = {64'(if2.data_out),  if2.serial_out,  7'(if2.bit_count),  if2.word_valid};
      obs_q.push_back(o);
   endtask

   task automatic test_reset;
      snap3_t e, o;
      drive(1'b1, 1'b0, MODE_HOLD, 1'b0, '0);
      drive(1'b1, 1'b1, MODE_LOAD, 1'b1, 64'hFFFF);
      checks++;
      if (if8.data_out !== 8'h3C || if8.bit_count !== 4'd0 || if8.word_valid !== 1'b0 || if8.serial_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_w8: got d=%h bc=%0d wv=%b so=%b, want d=3c bc=0 wv=0 so=0",
                  if8.data_out, if8.bit_count, if8.word_valid, if8.serial_out);
      end
      checks++;
      if (if2.data_out !== 2'b10) begin
         errors++;
         $display("FAIL reset_w2: got d=%b want d=10", if2.data_out);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL reset dut%0d: got %h want %h", k, o[k], e[k]); end
         end
      end
   endtask

   task automatic test_shl_word;
      snap3_t e, o;
      logic [7:0] bits;
      bits = 8'b1011_0101;
      for (int i = 7; i >= 0; i--) drive(1'b0, 1'b1, MODE_SHL, bits[i], '0);
      checks++;
      if (if8.data_out !== 8'hB5 || if8.word_valid !== 1'b1 || if8.bit_count !== 4'd0) begin
         errors++;
         $display("FAIL shl_word: got d=%h wv=%b bc=%0d, want d=b5 wv=1 bc=0",
                  if8.data_out, if8.word_valid, if8.bit_count);
      end
      drive(1'b0, 1'b1, MODE_HOLD, 1'b0, '0);
      checks++;
      if (if8.word_valid !== 1'b0) begin
         errors++; $display("FAIL shl_word_pulse: got wv=%b want wv=0", if8.word_valid);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL shl_word dut%0d: got %h want %h", k, o[k], e[k]); end
         end
      end
   endtask

   task automatic test_load_rotate;
      snap3_t e, o;
      drive(1'b0, 1'b1, MODE_LOAD, 1'b0, 64'h1234_5678_9ABC_C3A5);
      drive(1'b0, 1'b1, MODE_ROTL, 1'b0, '0);
      checks++;
      if (if8.data_out !== 8'h4B || if8.serial_out !== 1'b1 || if8.bit_count !== 4'd0 || if8.word_valid !== 1'b0) begin
         errors++;
         $display("FAIL load_rotl: got d=%h so=%b bc=%0d wv=%b, want d=4b so=1 bc=0 wv=0",
                  if8.data_out, if8.serial_out, if8.bit_count, if8.word_valid);
      end
      drive(1'b0, 1'b1, MODE_LOAD, 1'b1, 64'h0000_0000_0000_7E81);
      drive(1'b0, 1'b1, MODE_SHR, 1'b0, '0);
      checks++;
      if (if8.data_out !== 8'h40 || if8.serial_out !== 1'b1 || if8.bit_count !== 4'd1) begin
         errors++;
         $display("FAIL load_shr: got d=%h so=%b bc=%0d, want d=40 so=1 bc=1",
                  if8.data_out, if8.serial_out, if8.bit_count);
      end
      drive(1'b0, 1'b1, MODE_ROTR, 1'b0, '0);
      drive(1'b0, 1'b1, MODE_SHL, 1'b1, '0);
      drive(1'b0, 1'b1, MODE_SHR, 1'b1, '0);
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL load_rotate dut%0d: got %h want %h", k, o[k], e[k]); end
         end
      end
   endtask

   task automatic test_pause;
      snap3_t e, o;
      int pulses;
      pulses = 0;
      drive(1'b0, 1'b1, MODE_LOAD, 1'b0, '0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, MODE_SHL, 1'(i), '0);
         if (if8.word_valid) pulses++;
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, MODE_SHL, 1'b1, '0);
         checks++;
         if (if8.bit_count !== 4'd5 || if8.word_valid !== 1'b0) begin
            errors++;
            $display("FAIL pause_hold: got bc=%0d wv=%b, want bc=5 wv=0", if8.bit_count, if8.word_valid);
         end
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, MODE_SHL, 1'b1, '0);
         if (if8.word_valid) pulses++;
      end
      checks++;
      if (pulses !== 1 || if8.word_valid !== 1'b1) begin
         errors++;
         $display("FAIL pause_wrap: got pulses=%0d last_wv=%b, want pulses=1 last_wv=1", pulses, if8.word_valid);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL pause dut%0d: got %h want %h", k, o[k], e[k]); end
         end
      end
   endtask

   task automatic test_reset_midword;
      snap3_t e, o;
      int pulses;
      pulses = 0;
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, MODE_SHL, 1'b1, '0);
      drive(1'b1, 1'b1, MODE_SHL, 1'b1, '0);
      checks++;
      if (if8.data_out !== 8'h3C || if8.bit_count !== 4'd0) begin
         errors++;
         $display("FAIL midword_rst: got d=%h bc=%0d, want d=3c bc=0", if8.data_out, if8.bit_count);
      end
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, (i % 2 == 0) ? MODE_SHL : MODE_SHR, 1'(i), '0);
         if (if8.word_valid) pulses++;
      end
      checks++;
      if (pulses !== 1 || if8.word_valid !== 1'b1) begin
         errors++;
         $display("FAIL midword_count: got pulses=%0d last_wv=%b, want pulses=1 last_wv=1", pulses, if8.word_valid);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL midword dut%0d: got %h want %h", k, o[k], e[k]); end
         end
      end
   endtask

   task automatic test_reserved;
      snap3_t e, o;
      logic [7:0] d_before;
      logic [3:0] bc_before;
      logic       so_before;
      drive(1'b0, 1'b1, MODE_LOAD, 1'b0, 64'h0000_0000_0000_E6D9);
      drive(1'b0, 1'b1, MODE_SHR, 1'b1, '0);
      drive(1'b0, 1'b1, MODE_SHR, 1'b0, '0);
      d_before = if8.data_out; bc_before = if8.bit_count; so_before = if8.serial_out;
      for (int m = 6; m < 8; m++) begin
         drive(1'b0, 1'b1, 3'(m), 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
         checks++;
         if (if8.data_out !== d_before || if8.bit_count !== bc_before ||
             if8.serial_out !== so_before || if8.word_valid !== 1'b0) begin
            errors++;
            $display("FAIL reserved_mode%0d: got d=%h bc=%0d so=%b wv=%b, want d=%h bc=%0d so=%b wv=0",
                     m, if8.data_out, if8.bit_count, if8.serial_out, if8.word_valid,
                     d_before, bc_before, so_before);
         end
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL reserved dut%0d: got %h want %h", k, o[k], e[k]); end
         end
      end
   endtask

   task automatic test_back_to_back;
      snap3_t e, o;
      for (int i = 0; i < 120; i++) begin
         drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 4) != 0),
               3'($urandom_range(0, 7)), 1'($urandom), {$urandom, $urandom});
      end
      // Long SHL run so every width wraps several times back to back.
      for (int i = 0; i < 34; i++) drive(1'b0, 1'b1, MODE_SHL, 1'($urandom), '0);
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (o[k] !== e[k]) begin errors++; $display("FAIL back_to_back dut%0d: got %h want %h", k, o[k], e[k]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_shl_word();
      test_load_rotate();
      test_pause();
      test_reset_midword();
      test_reserved();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
